// File: rtl/lcd_sync_gen.sv
// Parametrised LCD timing generator: pixel-tick divider, h/v region counters and
// registered sync, data-enable and pixel-data outputs for the panel pads.
module lcd_sync_gen #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 20,
    parameter int H_SYNC_W = 30,
    parameter int H_BP     = 38,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC_W = 3,
    parameter int V_BP     = 15,
    parameter bit HS_ACT   = 1'b0,
    parameter bit VS_ACT   = 1'b0
) (
    input  logic                                                 sys_clk,
    input  logic                                                 sys_rst,
    input  logic                                                 en,
    input  logic [DATA_W-1:0]                                    pix_data,
    output logic                                                 pix_req,
    output logic [(H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1)-1:0]     pix_x,
    output logic [(V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1)-1:0]     pix_y,
    output logic                                                 pix_ce,
    output logic                                                 H_SYNC,
    output logic                                                 V_SYNC,
    output logic                                                 de,
    output logic [DATA_W-1:0]                                    dataLCD,
    output logic                                                 frame_start,
    output logic                                                 line_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [DW-1:0] DIV_LAST_C = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C     = HW'(H_ACTIVE + H_FP + H_SYNC_W);
    localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C     = VW'(V_ACTIVE + V_FP + V_SYNC_W);
    localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOT - 1);

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              ce_q, ce_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fs_q, fs_d;
    logic              ls_q, ls_d;

    logic act_h, act_v, in_hs, in_vs;

    assign act_h = (h_q < H_ACT_C);
    assign act_v = (v_q < V_ACT_C);
    assign in_hs = (h_q >= H_SS_C) && (h_q < H_SE_C);
    assign in_vs = (v_q >= V_SS_C) && (v_q < V_SE_C);

    assign pix_req     = en && ce_q && act_h && act_v;
    assign pix_x       = h_q[XW-1:0];
    assign pix_y       = v_q[YW-1:0];
    assign pix_ce      = ce_q;
    assign H_SYNC      = hs_q;
    assign V_SYNC      = vs_q;
    assign de          = de_q;
    assign dataLCD     = data_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

    // Outputs decode the counters as they stand at the tick edge, so they trail them by one tick.
    always_comb begin
        div_d  = '0;
        h_d    = '0;
        v_d    = '0;
        ce_d   = 1'b0;
        hs_d   = ~HS_ACT;
        vs_d   = ~VS_ACT;
        de_d   = 1'b0;
        data_d = '0;
        fs_d   = 1'b0;
        ls_d   = 1'b0;
        if (en) begin
            div_d  = (div_q == DIV_LAST_C) ? '0 : div_q + DW'(1);
            ce_d   = (div_d == DIV_LAST_C);
            h_d    = h_q;
            v_d    = v_q;
            hs_d   = hs_q;
            vs_d   = vs_q;
            de_d   = de_q;
            data_d = data_q;
            if (ce_q) begin
                if (h_q == H_LAST_C) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST_C) ? '0 : v_q + VW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
                de_d   = act_h && act_v;
                data_d = (act_h && act_v) ? pix_data : '0;
                hs_d   = in_hs ? HS_ACT : ~HS_ACT;
                vs_d   = in_vs ? VS_ACT : ~VS_ACT;
                ls_d   = (h_q == '0);
                fs_d   = (h_q == '0) && (v_q == '0);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            ce_q   <= 1'b0;
            hs_q   <= ~HS_ACT;
            vs_q   <= ~VS_ACT;
            de_q   <= 1'b0;
            data_q <= '0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            ce_q   <= ce_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            data_q <= data_d;
            fs_q   <= fs_d;
            ls_q   <= ls_d;
        end
    end

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Directed bench for lcd_sync_gen: a small 8x6 raster at CLK_DIV=2 with active-low
// syncs, plus an active-high CLK_DIV=1 variant sharing the same clock and controls.
module tb_lcd_sync_gen;

    logic       sysClk = 1'b0;
    logic       sysRst = 1'b1;
    logic       en     = 1'b0;
    logic [7:0] pixData;
    logic       pixReq, pixCe, hSync, vSync, de, frameStart, lineStart;
    logic [1:0] pixX, pixY;
    logic [7:0] dataLcd;

    logic       pixReq1, pixCe1, hSync1, vSync1, de1, frameStart1, lineStart1;
    logic [1:0] pixX1, pixY1;
    logic [7:0] dataLcd1;

    int errors = 0;
    int checks = 0;

    always #5 sysClk = ~sysClk;

    // The pixel source is combinational on the requested coordinates.
    assign pixData = {4'b0000, pixY, pixX};

    lcd_sync_gen #(
        .DATA_W(8), .CLK_DIV(2),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC_W(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC_W(1), .V_BP(1),
        .HS_ACT(1'b0), .VS_ACT(1'b0)
    ) dut (
        .sys_clk(sysClk), .sys_rst(sysRst), .en(en), .pix_data(pixData),
        .pix_req(pixReq), .pix_x(pixX), .pix_y(pixY), .pix_ce(pixCe),
        .H_SYNC(hSync), .V_SYNC(vSync), .de(de), .dataLCD(dataLcd),
        .frame_start(frameStart), .line_start(lineStart)
    );

    lcd_sync_gen #(
        .DATA_W(8), .CLK_DIV(1),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC_W(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC_W(1), .V_BP(1),
        .HS_ACT(1'b1), .VS_ACT(1'b1)
    ) dut1 (
        .sys_clk(sysClk), .sys_rst(sysRst), .en(en), .pix_data(8'hA5),
        .pix_req(pixReq1), .pix_x(pixX1), .pix_y(pixY1), .pix_ce(pixCe1),
        .H_SYNC(hSync1), .V_SYNC(vSync1), .de(de1), .dataLCD(dataLcd1),
        .frame_start(frameStart1), .line_start(lineStart1)
    );

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic test_reset();
        sysRst = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({hSync, vSync, de, dataLcd, pixCe} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_idle: hs,vs,de,data,ce=%b,%b,%b,%h,%b required 1,1,0,00,0",
                         hSync, vSync, de, dataLcd, pixCe);
            end
        end
        sysRst = 1'b0;
        checks++;
        if (pixCe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ce_release_cycle1: pix_ce=%b required 0", pixCe);
        end
        tick();
        checks++;
        if (pixCe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ce_release_cycle2: pix_ce=%b required 1", pixCe);
        end
        checks++;
        if (pixReq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_first_tick: pix_req=%b required 1", pixReq);
        end
        tick();
        checks++;
        if ({frameStart, lineStart, de, pixCe, dataLcd} !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL first_outputs: fs,ls,de,ce,data=%b,%b,%b,%b,%h required 1,1,1,0,00",
                     frameStart, lineStart, de, pixCe, dataLcd);
        end
    endtask

    // Entered in the cycle frame_start is visible; leaves one frame later.
    task automatic test_line_timing();
        int   deCount[6];
        int   lastLs = -1;
        int   lowStart = -1;
        int   lsSeen = 0;
        int   hsPulses = 0;
        int   badZero = 0;
        logic prevHs = 1'b1;
        for (int l = 0; l < 6; l++) deCount[l] = 0;
        for (int n = 0; n < 96; n++) begin
            if (de) deCount[n / 16]++;
            if (!de && dataLcd !== 8'h00) badZero++;
            if (lineStart) begin
                if (lastLs >= 0) begin
                    checks++;
                    if (n - lastLs !== 16) begin
                        errors++;
                        $display("[TB] FAIL ls_spacing: spacing=%0d required 16", n - lastLs);
                    end
                end
                lastLs = n;
                lsSeen++;
            end
            if (prevHs && !hSync) begin
                lowStart = n;
                checks++;
                if (n - lastLs !== 10) begin
                    errors++;
                    $display("[TB] FAIL hsync_offset: offset=%0d required 10", n - lastLs);
                end
            end
            if (!prevHs && hSync) begin
                hsPulses++;
                checks++;
                if (n - lowStart !== 4) begin
                    errors++;
                    $display("[TB] FAIL hsync_width: width=%0d required 4", n - lowStart);
                end
            end
            prevHs = hSync;
            tick();
        end
        for (int l = 0; l < 6; l++) begin
            checks++;
            if (deCount[l] !== (l < 3 ? 8 : 0)) begin
                errors++;
                $display("[TB] FAIL de_count line %0d: count=%0d required %0d", l, deCount[l], (l < 3 ? 8 : 0));
            end
        end
        checks++;
        if (badZero !== 0) begin
            errors++;
            $display("[TB] FAIL data_zero: %0d cycles with de=0 and data!=0, required 0", badZero);
        end
        checks++;
        if (lsSeen !== 6 || hsPulses !== 6) begin
            errors++;
            $display("[TB] FAIL line_counts: line_starts=%0d hsync_pulses=%0d required 6,6", lsSeen, hsPulses);
        end
    endtask

    task automatic test_frame_timing();
        int   lastFs = -1;
        int   fsSeen = 0;
        int   vsLow = -1;
        int   vsPulses = 0;
        logic prevVs = 1'b1;
        for (int n = 0; n < 288; n++) begin
            if (frameStart) begin
                if (lastFs >= 0) begin
                    checks++;
                    if (n - lastFs !== 96) begin
                        errors++;
                        $display("[TB] FAIL fs_spacing: spacing=%0d required 96", n - lastFs);
                    end
                end
                lastFs = n;
                fsSeen++;
            end
            if (prevVs && !vSync) begin
                vsLow = n;
                checks++;
                if (n % 96 !== 64) begin
                    errors++;
                    $display("[TB] FAIL vsync_start: frame offset=%0d required 64", n % 96);
                end
            end
            if (!prevVs && vSync) begin
                vsPulses++;
                checks++;
                if (n - vsLow !== 16) begin
                    errors++;
                    $display("[TB] FAIL vsync_width: width=%0d required 16", n - vsLow);
                end
            end
            prevVs = vSync;
            tick();
        end
        checks++;
        if (fsSeen !== 3 || vsPulses !== 3) begin
            errors++;
            $display("[TB] FAIL frame_counts: frame_starts=%0d vsync_pulses=%0d required 3,3", fsSeen, vsPulses);
        end
    endtask

    // Entered at a frame_start cycle; each pixel is held for two sys_clk cycles.
    task automatic test_data_path();
        int         h;
        int         line;
        logic [7:0] expData;
        for (int n = 0; n < 32; n++) begin
            if (n % 2 == 0) begin
                h    = (n % 16) / 2;
                line = n / 16;
                if (h < 4) begin
                    expData = 8'(line * 4 + h);
                    checks++;
                    if (de !== 1'b1 || dataLcd !== expData) begin
                        errors++;
                        $display("[TB] FAIL data_pixel line %0d x %0d: de=%b data=%h required 1,%h",
                                 line, h, de, dataLcd, expData);
                    end
                end else begin
                    checks++;
                    if (de !== 1'b0 || dataLcd !== 8'h00) begin
                        errors++;
                        $display("[TB] FAIL data_blank line %0d x %0d: de=%b data=%h required 0,00",
                                 line, h, de, dataLcd);
                    end
                end
            end
            tick();
        end
    endtask

    // Entered 32 cycles into a frame.
    task automatic test_enable_abort();
        int lsCount = 0;
        int fsAt = -1;
        for (int i = 0; i < 64 + 20; i++) tick();
        checks++;
        if (de !== 1'b1 || dataLcd !== 8'h06) begin
            errors++;
            $display("[TB] FAIL abort_pre: de=%b data=%h required 1,06", de, dataLcd);
        end
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({hSync, vSync, de, dataLcd, pixCe, lineStart, frameStart, pixReq} !==
                {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL abort_idle cycle %0d: hs,vs,de,data,ce,ls,fs,req=%b,%b,%b,%h,%b,%b,%b,%b required 1,1,0,00,0,0,0,0",
                         i, hSync, vSync, de, dataLcd, pixCe, lineStart, frameStart, pixReq);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (pixCe !== 1'b1 || frameStart !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_ce: ce,fs=%b,%b required 1,0", pixCe, frameStart);
        end
        tick();
        checks++;
        if (frameStart !== 1'b1 || lineStart !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_fs: fs,ls=%b,%b required 1,1", frameStart, lineStart);
        end
        for (int n = 1; n <= 96; n++) begin
            tick();
            if (lineStart) lsCount++;
            if (frameStart && fsAt < 0) fsAt = n;
        end
        checks++;
        if (lsCount !== 6 || fsAt !== 96) begin
            errors++;
            $display("[TB] FAIL restart_timing: line_starts=%0d next_fs=%0d required 6,96", lsCount, fsAt);
        end
    endtask

    task automatic test_polarity();
        int   fsAt = -1;
        int   hsRise = -1;
        int   hsPulses = 0;
        int   vsRise = -1;
        int   wait1 = 0;
        logic prevHs = 1'b0;
        logic prevVs = 1'b0;
        sysRst = 1'b1;
        tick();
        tick();
        checks++;
        if ({hSync1, vSync1, de1, pixCe1} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL pol_reset: hs,vs,de,ce=%b,%b,%b,%b required 0,0,0,0", hSync1, vSync1, de1, pixCe1);
        end
        sysRst = 1'b0;
        while (!frameStart1 && wait1 < 10) begin
            tick();
            wait1++;
        end
        checks++;
        if (frameStart1 !== 1'b1 || wait1 !== 2) begin
            errors++;
            $display("[TB] FAIL pol_first_fs: fs=%b after %0d cycles required 1 after 2", frameStart1, wait1);
        end
        for (int n = 0; n <= 48; n++) begin
            if (n > 0 && frameStart1 && fsAt < 0) fsAt = n;
            if (!prevHs && hSync1) hsRise = n;
            if (prevHs && !hSync1) begin
                hsPulses++;
                checks++;
                if (n - hsRise !== 2) begin
                    errors++;
                    $display("[TB] FAIL pol_hsync_width: width=%0d required 2", n - hsRise);
                end
            end
            if (!prevVs && vSync1) vsRise = n;
            if (prevVs && !vSync1) begin
                checks++;
                if (vsRise !== 32 || n - vsRise !== 8) begin
                    errors++;
                    $display("[TB] FAIL pol_vsync: start=%0d width=%0d required 32,8", vsRise, n - vsRise);
                end
            end
            prevHs = hSync1;
            prevVs = vSync1;
            tick();
        end
        checks++;
        if (fsAt !== 48 || hsPulses !== 6) begin
            errors++;
            $display("[TB] FAIL pol_frame: next_fs=%0d hsync_pulses=%0d required 48,6", fsAt, hsPulses);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_data_path();
        test_enable_abort();
        test_polarity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
